decode_stage: RTL and testbench

Y86-64 pipeline decode stage. It sits directly downstream of the fetch block and contains three parts:
- the D pipeline register, which latches the f_* fetch outputs under stall/bubble control;
- the 15-entry architectural register file, whose write port is driven by the writeback stage;
- source/destination selection plus data forwarding.
It produces the d_* values consumed by the E pipeline register.

---
 rtl/y86_pkg.sv | 28 ++
 rtl/regfile.sv | 43 ++++
 rtl/decode_stage.sv | 167 ++++++++++++++++
 tb/tb_decode_stage.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, special register IDs and status codes.
package y86_pkg;

  // Instruction codes, as held in the icode field
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Stack pointer, and the ID meaning "no register"
  localparam logic [3:0] REG_RSP  = 4'h4;
  localparam logic [3:0] REG_NONE = 4'hF;

  // Pipeline status codes
  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

endpackage

// File: rtl/regfile.sv
// Architectural register file: two combinational read ports, two posedge write
// ports (E and M), synchronous active-high reset. ID F reads as zero and never writes.
module regfile
  import y86_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        src_a,
  input  logic [3:0]        src_b,
  output logic [DATA_W-1:0] val_a,
  output logic [DATA_W-1:0] val_b,
  input  logic [3:0]        dst_e,
  input  logic [DATA_W-1:0] wr_val_e,
  input  logic [3:0]        dst_m,
  input  logic [DATA_W-1:0] wr_val_m
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  // Next register contents; the M port is applied last so it wins on a shared ID
  always_comb begin
    regs_d = regs_q;
    if (dst_e != REG_NONE) regs_d[dst_e] = wr_val_e;
    if (dst_m != REG_NONE) regs_d[dst_m] = wr_val_m;
  end

  // Register array update; reset clears every entry and blocks writes that cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign val_a = (src_a == REG_NONE) ? '0 : regs_q[src_a];
  assign val_b = (src_b == REG_NONE) ? '0 : regs_q[src_b];

endmodule

// File: rtl/decode_stage.sv
// Y86-64 decode stage: D pipeline register, register file, operand source and
// destination selection, and forwarding from execute, memory and writeback.
module decode_stage
  import y86_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              D_stall,
  input  logic              D_bubble,
  input  logic [1:0]        f_stat,
  input  logic [3:0]        f_icode,
  input  logic [3:0]        f_ifun,
  input  logic [3:0]        f_rA,
  input  logic [3:0]        f_rB,
  input  logic [DATA_W-1:0] f_valC,
  input  logic [DATA_W-1:0] f_valP,
  input  logic [3:0]        e_dstE,
  input  logic [DATA_W-1:0] e_valE,
  input  logic [3:0]        M_dstE,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [3:0]        M_dstM,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [3:0]        W_dstE,
  input  logic [DATA_W-1:0] W_valE,
  input  logic [3:0]        W_dstM,
  input  logic [DATA_W-1:0] W_valM,
  output logic [1:0]        d_stat,
  output logic [3:0]        d_icode,
  output logic [3:0]        d_ifun,
  output logic [DATA_W-1:0] d_valC,
  output logic [DATA_W-1:0] d_valA,
  output logic [DATA_W-1:0] d_valB,
  output logic [3:0]        d_srcA,
  output logic [3:0]        d_srcB,
  output logic [3:0]        d_dstE,
  output logic [3:0]        d_dstM
);

  logic [1:0]        stat_q,  stat_d;
  logic [3:0]        icode_q, icode_d;
  logic [3:0]        ifun_q,  ifun_d;
  logic [3:0]        ra_q,    ra_d;
  logic [3:0]        rb_q,    rb_d;
  logic [DATA_W-1:0] valc_q,  valc_d;
  logic [DATA_W-1:0] valp_q,  valp_d;

  logic [DATA_W-1:0] rf_val_a, rf_val_b;

  // D register next state: stall holds (even if bubble is also set), bubble injects a nop
  always_comb begin
    stat_d  = stat_q;
    icode_d = icode_q;
    ifun_d  = ifun_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    valc_d  = valc_q;
    valp_d  = valp_q;
    if (!D_stall) begin
      if (D_bubble) begin
        stat_d  = STAT_AOK;
        icode_d = INOP;
        ifun_d  = 4'h0;
        ra_d    = REG_NONE;
        rb_d    = REG_NONE;
        valc_d  = '0;
        valp_d  = '0;
      end else begin
        stat_d  = f_stat;
        icode_d = f_icode;
        ifun_d  = f_ifun;
        ra_d    = f_rA;
        rb_d    = f_rB;
        valc_d  = f_valC;
        valp_d  = f_valP;
      end
    end
  end

  // D register flops; reset loads the same nop as a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_q  <= STAT_AOK;
      icode_q <= INOP;
      ifun_q  <= 4'h0;
      ra_q    <= REG_NONE;
      rb_q    <= REG_NONE;
      valc_q  <= '0;
      valp_q  <= '0;
    end else begin
      stat_q  <= stat_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      valc_q  <= valc_d;
      valp_q  <= valp_d;
    end
  end

  // Source and destination register IDs from the latched instruction
  always_comb begin
    d_srcA = REG_NONE;
    d_srcB = REG_NONE;
    d_dstE = REG_NONE;
    d_dstM = REG_NONE;
    case (icode_q)
      IRRMOVQ: begin d_srcA = ra_q; d_dstE = rb_q; end
      IIRMOVQ: d_dstE = rb_q;
      IRMMOVQ: begin d_srcA = ra_q; d_srcB = rb_q; end
      IMRMOVQ: begin d_srcB = rb_q; d_dstM = ra_q; end
      IOPQ:    begin d_srcA = ra_q; d_srcB = rb_q; d_dstE = rb_q; end
      ICALL:   begin d_srcB = REG_RSP; d_dstE = REG_RSP; end
      IRET:    begin d_srcA = REG_RSP; d_srcB = REG_RSP; d_dstE = REG_RSP; end
      IPUSHQ:  begin d_srcA = ra_q; d_srcB = REG_RSP; d_dstE = REG_RSP; end
      IPOPQ:   begin d_srcA = REG_RSP; d_srcB = REG_RSP; d_dstE = REG_RSP; d_dstM = ra_q; end
      default: ;
    endcase
  end

  regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .src_a    (d_srcA),
    .src_b    (d_srcB),
    .val_a    (rf_val_a),
    .val_b    (rf_val_b),
    .dst_e    (W_dstE),
    .wr_val_e (W_valE),
    .dst_m    (W_dstM),
    .wr_val_m (W_valM)
  );

  // A operand: valP for jumps/calls, otherwise youngest matching producer wins
  always_comb begin
    d_valA = rf_val_a;
    if (icode_q == ICALL || icode_q == IJXX) d_valA = valp_q;
    else if (d_srcA == REG_NONE)             d_valA = '0;
    else if (d_srcA == e_dstE)               d_valA = e_valE;
    else if (d_srcA == M_dstM)               d_valA = m_valM;
    else if (d_srcA == M_dstE)               d_valA = M_valE;
    else if (d_srcA == W_dstM)               d_valA = W_valM;
    else if (d_srcA == W_dstE)               d_valA = W_valE;
  end

  // B operand: same forwarding chain, never replaced by valP
  always_comb begin
    d_valB = rf_val_b;
    if (d_srcB == REG_NONE)    d_valB = '0;
    else if (d_srcB == e_dstE) d_valB = e_valE;
    else if (d_srcB == M_dstM) d_valB = m_valM;
    else if (d_srcB == M_dstE) d_valB = M_valE;
    else if (d_srcB == W_dstM) d_valB = W_valM;
    else if (d_srcB == W_dstE) d_valB = W_valE;
  end

  assign d_stat  = stat_q;
  assign d_icode = icode_q;
  assign d_ifun  = ifun_q;
  assign d_valC  = valc_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage: reset, register file write priority,
// forwarding priority, valP override, stall/bubble control.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        D_stall, D_bubble;
  logic [1:0]  f_stat;
  logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
  logic [63:0] f_valC, f_valP;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [1:0]  d_stat;
  logic [3:0]  d_icode, d_ifun, d_srcA, d_srcB, d_dstE, d_dstM;
  logic [63:0] d_valC, d_valA, d_valB;

  int compared   = 0;
  int mismatched = 0;

  decode_stage #(.DATA_W(64), .NUM_REGS(15)) dut (
    .clk(clk), .rst(rst), .D_stall(D_stall), .D_bubble(D_bubble),
    .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
    .f_valC(f_valC), .f_valP(f_valP),
    .e_dstE(e_dstE), .e_valE(e_valE), .M_dstE(M_dstE), .M_valE(M_valE),
    .M_dstM(M_dstM), .m_valM(m_valM), .W_dstE(W_dstE), .W_valE(W_valE),
    .W_dstM(W_dstM), .W_valM(W_valM),
    .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun), .d_valC(d_valC),
    .d_valA(d_valA), .d_valB(d_valB), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .d_dstE(d_dstE), .d_dstM(d_dstM)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  // Advance one active edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Clear all forwarding/writeback sources to "none"
  task automatic clear_fwd();
    e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
    e_valE = '0;   M_valE = '0;   m_valM = '0;   W_valE = '0;   W_valM = '0;
  endtask

  // Present one fetched instruction and clock it into D
  task automatic load_instr(input logic [3:0] icode, input logic [3:0] ra, input logic [3:0] rb,
                            input logic [63:0] valc, input logic [63:0] valp,
                            input logic [1:0] stat);
    f_icode = icode; f_ifun = 4'h0; f_rA = ra; f_rB = rb;
    f_valC = valc; f_valP = valp; f_stat = stat;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    W_dstE = 4'h6; W_valE = 64'hDEAD;
    tick();
    compared++; if (d_icode !== 4'h1) begin mismatched++; $display("[TB] FAIL reset_icode: got %h want 1", d_icode); end
    compared++; if (d_stat !== 2'd0) begin mismatched++; $display("[TB] FAIL reset_stat: got %h want 0", d_stat); end
    compared++; if ({d_srcA, d_srcB, d_dstE, d_dstM} !== 16'hFFFF) begin mismatched++; $display("[TB] FAIL reset_ids: got %h want ffff", {d_srcA, d_srcB, d_dstE, d_dstM}); end
    compared++; if (d_valA !== 64'h0 || d_valB !== 64'h0 || d_valC !== 64'h0) begin mismatched++; $display("[TB] FAIL reset_vals: got A=%h B=%h C=%h want 0", d_valA, d_valB, d_valC); end
    rst = 1'b0;
    clear_fwd();
    for (int r = 0; r < 15; r++) begin
      load_instr(4'h6, r[3:0], r[3:0], 64'h0, 64'h0, 2'd0);
      compared++; if (d_valA !== 64'h0 || d_valB !== 64'h0) begin mismatched++; $display("[TB] FAIL reset_reg%0d: got A=%h B=%h want 0", r, d_valA, d_valB); end
    end
  endtask

  task automatic test_writeback();
    W_dstE = 4'h3; W_valE = 64'h55; W_dstM = 4'h3; W_valM = 64'hAA;
    tick();
    clear_fwd();
    load_instr(4'h6, 4'h3, 4'h2, 64'h0, 64'h0, 2'd0);
    compared++; if (d_valA !== 64'hAA) begin mismatched++; $display("[TB] FAIL wb_valA: got %h want aa", d_valA); end
    compared++; if (d_srcA !== 4'h3 || d_srcB !== 4'h2) begin mismatched++; $display("[TB] FAIL wb_src: got %h/%h want 3/2", d_srcA, d_srcB); end
    compared++; if (d_dstE !== 4'h2 || d_dstM !== 4'hF) begin mismatched++; $display("[TB] FAIL wb_dst: got %h/%h want 2/f", d_dstE, d_dstM); end
    compared++; if (d_valB !== 64'h0) begin mismatched++; $display("[TB] FAIL wb_valB: got %h want 0", d_valB); end
  endtask

  task automatic test_forward_priority();
    load_instr(4'h4, 4'h1, 4'h2, 64'h8, 64'h0, 2'd0);
    e_dstE = 4'h1; e_valE = 64'h10; M_dstE = 4'h1; M_valE = 64'h20;
    #1;
    compared++; if (d_valA !== 64'h10) begin mismatched++; $display("[TB] FAIL fwd_execute: got %h want 10", d_valA); end
    e_dstE = 4'hF;
    #1;
    compared++; if (d_valA !== 64'h20) begin mismatched++; $display("[TB] FAIL fwd_mem_valE: got %h want 20", d_valA); end
    M_dstM = 4'h1; m_valM = 64'h30;
    #1;
    compared++; if (d_valA !== 64'h30) begin mismatched++; $display("[TB] FAIL fwd_mem_valM: got %h want 30", d_valA); end
    W_dstE = 4'h2; W_valE = 64'h77; W_dstM = 4'h2; W_valM = 64'h88;
    #1;
    compared++; if (d_valB !== 64'h88) begin mismatched++; $display("[TB] FAIL fwd_wb_valM: got %h want 88", d_valB); end
    W_dstM = 4'hF;
    #1;
    compared++; if (d_valB !== 64'h77) begin mismatched++; $display("[TB] FAIL fwd_wb_valE: got %h want 77", d_valB); end
    compared++; if (d_valC !== 64'h8 || d_dstE !== 4'hF) begin mismatched++; $display("[TB] FAIL rmmov_fields: got C=%h dstE=%h want 8/f", d_valC, d_dstE); end
    clear_fwd();
  endtask

  task automatic test_popq();
    load_instr(4'hB, 4'h5, 4'hF, 64'h0, 64'h0, 2'd0);
    M_dstM = 4'h4; m_valM = 64'h100;
    #1;
    compared++; if (d_srcA !== 4'h4 || d_srcB !== 4'h4) begin mismatched++; $display("[TB] FAIL pop_src: got %h/%h want 4/4", d_srcA, d_srcB); end
    compared++; if (d_valA !== 64'h100 || d_valB !== 64'h100) begin mismatched++; $display("[TB] FAIL pop_vals: got %h/%h want 100/100", d_valA, d_valB); end
    compared++; if (d_dstE !== 4'h4 || d_dstM !== 4'h5) begin mismatched++; $display("[TB] FAIL pop_dst: got %h/%h want 4/5", d_dstE, d_dstM); end
    clear_fwd();
  endtask

  task automatic test_call();
    load_instr(4'h8, 4'hF, 4'hF, 64'h40, 64'h2A, 2'd0);
    e_dstE = 4'h4; e_valE = 64'h999;
    #1;
    compared++; if (d_valA !== 64'h2A) begin mismatched++; $display("[TB] FAIL call_valP: got %h want 2a", d_valA); end
    compared++; if (d_srcB !== 4'h4 || d_srcA !== 4'hF) begin mismatched++; $display("[TB] FAIL call_src: got %h/%h want f/4", d_srcA, d_srcB); end
    compared++; if (d_valB !== 64'h999) begin mismatched++; $display("[TB] FAIL call_valB: got %h want 999", d_valB); end
    compared++; if (d_dstE !== 4'h4) begin mismatched++; $display("[TB] FAIL call_dstE: got %h want 4", d_dstE); end
    clear_fwd();
  endtask

  task automatic test_stall_bubble();
    load_instr(4'h3, 4'hF, 4'h7, 64'h1234, 64'h0, 2'd2);
    compared++; if (d_icode !== 4'h3 || d_dstE !== 4'h7 || d_valC !== 64'h1234 || d_stat !== 2'd2) begin mismatched++; $display("[TB] FAIL irmov_load: got i=%h dE=%h C=%h s=%h want 3/7/1234/2", d_icode, d_dstE, d_valC, d_stat); end
    D_stall = 1'b1;
    load_instr(4'h6, 4'h1, 4'h2, 64'h9, 64'h0, 2'd0);
    compared++; if (d_icode !== 4'h3 || d_dstE !== 4'h7 || d_valC !== 64'h1234 || d_stat !== 2'd2) begin mismatched++; $display("[TB] FAIL stall_hold: got i=%h dE=%h C=%h s=%h want 3/7/1234/2", d_icode, d_dstE, d_valC, d_stat); end
    D_stall = 1'b0; D_bubble = 1'b1;
    tick();
    compared++; if (d_icode !== 4'h1 || {d_srcA, d_srcB, d_dstE, d_dstM} !== 16'hFFFF || d_valC !== 64'h0 || d_stat !== 2'd0) begin mismatched++; $display("[TB] FAIL bubble: got i=%h ids=%h C=%h s=%h want 1/ffff/0/0", d_icode, {d_srcA, d_srcB, d_dstE, d_dstM}, d_valC, d_stat); end
    D_bubble = 1'b0;
    load_instr(4'h3, 4'hF, 4'h7, 64'h1234, 64'h0, 2'd0);
    D_stall = 1'b1; D_bubble = 1'b1;
    load_instr(4'h5, 4'h1, 4'h2, 64'h9, 64'h0, 2'd0);
    compared++; if (d_icode !== 4'h3 || d_dstE !== 4'h7 || d_valC !== 64'h1234) begin mismatched++; $display("[TB] FAIL stall_and_bubble: got i=%h dE=%h C=%h want 3/7/1234", d_icode, d_dstE, d_valC); end
    D_stall = 1'b0; D_bubble = 1'b0;
  endtask

  task automatic test_reset_clears_reg();
    load_instr(4'h6, 4'h3, 4'h3, 64'h0, 64'h0, 2'd0);
    compared++; if (d_valA !== 64'hAA) begin mismatched++; $display("[TB] FAIL reg3_before_reset: got %h want aa", d_valA); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    load_instr(4'h6, 4'h3, 4'h6, 64'h0, 64'h0, 2'd0);
    compared++; if (d_valA !== 64'h0 || d_valB !== 64'h0) begin mismatched++; $display("[TB] FAIL reg_after_reset: got %h/%h want 0/0", d_valA, d_valB); end
  endtask

  initial begin
    rst = 1'b1; D_stall = 1'b0; D_bubble = 1'b0;
    f_stat = '0; f_icode = 4'h1; f_ifun = '0; f_rA = 4'hF; f_rB = 4'hF;
    f_valC = '0; f_valP = '0;
    clear_fwd();
    #2;
    test_reset();
    test_writeback();
    test_forward_priority();
    test_popq();
    test_call();
    test_stall_bubble();
    test_reset_clears_reg();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
